// File: rtl/porta_logica_param.sv
// ---------------------------------------------------------------------------
// porta_logica_param
//
// Registered two-operand bitwise logic unit with an OR/AND reduction
// accumulator and a one-entry valid/ready output register.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid and ready are both 1.
//   A producer holding valid=1 must keep its payload stable until it is
//   taken; ready may depend combinationally on the downstream ready only.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 1)
//   CNT_W  width of the saturating accepted-transaction counter (>= 1)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   a/b/op carry a transaction this cycle
//   in_ready   unit can take a transaction this cycle (= !out_valid | out_ready)
//   a, b       operands
//   op         function select:
//                000 AND  001 OR  010 XOR  011 NAND  100 NOR  101 XNOR
//                110 ACC_OR  111 ACC_AND
//   clr        single-cycle strobe clearing the accumulator
//   out_valid  y holds a result that has not been consumed yet
//   out_ready  downstream takes y this cycle
//   y          registered result
//   cnt        number of accepted transactions, saturating at all-ones
// ---------------------------------------------------------------------------
module porta_logica_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [CNT_W-1:0] cnt
);

    typedef enum logic [2:0] {
        OP_AND     = 3'b000,
        OP_OR      = 3'b001,
        OP_XOR     = 3'b010,
        OP_NAND    = 3'b011,
        OP_NOR     = 3'b100,
        OP_XNOR    = 3'b101,
        OP_ACC_OR  = 3'b110,
        OP_ACC_AND = 3'b111
    } op_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Accumulator state. 'first' marks that the next accumulate operation
    // must load its operand result instead of combining with acc.
    logic [WIDTH-1:0] acc;
    logic             first;

    logic             accept;
    logic             handoff;
    logic             is_acc;
    logic             acc_fresh;
    logic [WIDTH-1:0] and_r;
    logic [WIDTH-1:0] or_r;
    logic [WIDTH-1:0] acc_new;
    logic [WIDTH-1:0] result;

    // The output register can take new data when it is empty or is being
    // drained this very cycle, which gives full throughput.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign handoff  = out_valid && out_ready;

    assign and_r = a & b;
    assign or_r  = a | b;

    // A clear arriving together with an accumulate transaction wins: the
    // transaction then behaves as the first of a new reduction.
    assign acc_fresh = first || clr;

    always_comb begin
        is_acc  = 1'b0;
        acc_new = acc;
        result  = '0;
        case (op_e'(op))
            OP_AND:  result = and_r;
            OP_OR:   result = or_r;
            OP_XOR:  result = a ^ b;
            OP_NAND: result = ~and_r;
            OP_NOR:  result = ~or_r;
            OP_XNOR: result = ~(a ^ b);
            OP_ACC_OR: begin
                is_acc  = 1'b1;
                acc_new = acc_fresh ? or_r : (acc | or_r);
                result  = acc_new;
            end
            OP_ACC_AND: begin
                is_acc  = 1'b1;
                acc_new = acc_fresh ? and_r : (acc & and_r);
                result  = acc_new;
            end
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            first     <= 1'b1;
            y         <= '0;
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            // Accumulator: an accepted accumulate op already folded any
            // coincident clr into acc_new, so it takes priority here.
            if (accept && is_acc) begin
                acc   <= acc_new;
                first <= 1'b0;
            end else if (clr) begin
                acc   <= '0;
                first <= 1'b1;
            end

            // Output register and counter.
            if (accept) begin
                y         <= result;
                out_valid <= 1'b1;
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + 1'b1;
                end
            end else if (handoff) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_porta_logica_param.sv
module tb_porta_logica_param;

    localparam int W = 8;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic [7:0]   cnt;

    // Second instance sharing all inputs, with a 2-bit counter for saturation.
    logic         in_ready2;
    logic         out_valid2;
    logic [W-1:0] y2;
    logic [1:0]   cnt2;

    always #5 clk = ~clk;

    porta_logica_param #(.WIDTH(W), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .clr(clr), .out_valid(out_valid),
        .out_ready(out_ready), .y(y), .cnt(cnt)
    );

    porta_logica_param #(.WIDTH(W), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .op(op), .clr(clr), .out_valid(out_valid2),
        .out_ready(out_ready), .y(y2), .cnt(cnt2)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    logic [W-1:0] m_acc;
    logic         m_first;
    logic [W-1:0] m_y;
    logic         m_ov;
    int           m_cnt;
    int           m_cnt2;

    function automatic logic [W-1:0] ref_logic(input logic [2:0] f,
                                               input logic [W-1:0] x,
                                               input logic [W-1:0] z);
        case (f)
            3'd0:    return x & z;
            3'd1:    return x | z;
            3'd2:    return x ^ z;
            3'd3:    return ~(x & z);
            3'd4:    return ~(x | z);
            default: return ~(x ^ z);
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic         acc_take;
        logic [W-1:0] r;
        logic [W-1:0] nxt;
        if (rst) begin
            m_acc = '0; m_first = 1'b1; m_y = '0; m_ov = 1'b0;
            m_cnt = 0; m_cnt2 = 0;
        end else begin
            acc_take = in_valid && (!m_ov || out_ready);
            if (acc_take && op >= 3'd6) begin
                r   = (op == 3'd6) ? (a | b) : (a & b);
                if (m_first || clr)  nxt = r;
                else if (op == 3'd6) nxt = m_acc | r;
                else                 nxt = m_acc & r;
                m_acc   = nxt;
                m_first = 1'b0;
                m_y     = nxt;
            end else if (clr) begin
                m_acc   = '0;
                m_first = 1'b1;
            end
            if (acc_take && op < 3'd6) m_y = ref_logic(op, a, b);
            if (acc_take) begin
                m_ov   = 1'b1;
                m_cnt  = (m_cnt  < 255) ? m_cnt + 1  : 255;
                m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drive one cycle of inputs, advance through the rising edge, sample #1 later.
    task automatic drive(input logic iv, input logic [W-1:0] da,
                         input logic [W-1:0] db, input logic [2:0] dop,
                         input logic dclr, input logic ordy);
        in_valid  = iv;
        a         = da;
        b         = db;
        op        = dop;
        clr       = dclr;
        out_ready = ordy;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, '0, '0, 3'd0, 1'b0, 1'b1);
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 8'hFF, 8'hFF, 3'd1, 1'b0, 1'b1);
        drive(1'b1, 8'hFF, 8'hFF, 3'd1, 1'b0, 1'b1);
        n_vec++;
        if (y !== 8'h00 || out_valid !== 1'b0 || cnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset_state: y=%h out_valid=%b cnt=%0d, required y=00 out_valid=0 cnt=0",
                     y, out_valid, cnt);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_function_sweep();
        logic [W-1:0] exp_y [6];
        exp_y = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'hF0, 8'h3C, 3'(i), 1'b0, 1'b1);
            n_vec++;
            if (y !== exp_y[i] || out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL sweep_op%0d: y=%h out_valid=%b, required y=%h out_valid=1",
                         i, y, out_valid, exp_y[i]);
            end
        end
        n_vec++;
        if (cnt !== 8'd6) begin
            n_err++;
            $display("FAIL sweep_cnt: cnt=%0d required 6", cnt);
        end
    endtask

    task automatic test_accumulate();
        logic [W-1:0] ta [5];
        logic [W-1:0] tb [5];
        logic [2:0]   top [5];
        logic         tclr [5];
        logic [W-1:0] texp [5];
        ta   = '{8'h01, 8'h00, 8'h80, 8'hFF, 8'h3C};
        tb   = '{8'h00, 8'h10, 8'h80, 8'h0F, 8'hFF};
        top  = '{3'd6, 3'd6, 3'd6, 3'd7, 3'd7};
        tclr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        texp = '{8'h01, 8'h11, 8'h91, 8'h0F, 8'h0C};
        do_reset();
        drive(1'b0, '0, '0, 3'd0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ta[i], tb[i], top[i], tclr[i], 1'b1);
            n_vec++;
            if (y !== texp[i]) begin
                n_err++;
                $display("FAIL accumulate_step%0d: y=%h required %h", i, y, texp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1'b1, 8'hAA, 8'h55, 3'd1, 1'b0, 1'b0);
        in_valid = 1'b1; a = 8'h01; b = 8'h02; op = 3'd1; out_ready = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_in_ready_low: in_ready=%b required 0", in_ready);
        end
        drive(1'b1, 8'h01, 8'h02, 3'd1, 1'b0, 1'b0);
        n_vec++;
        if (y !== 8'hFF || out_valid !== 1'b1 || cnt !== 8'd1) begin
            n_err++;
            $display("FAIL bp_hold: y=%h out_valid=%b cnt=%0d, required y=ff out_valid=1 cnt=1",
                     y, out_valid, cnt);
        end
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_in_ready_high: in_ready=%b required 1", in_ready);
        end
        drive(1'b1, 8'h01, 8'h02, 3'd1, 1'b0, 1'b1);
        n_vec++;
        if (y !== 8'h03 || out_valid !== 1'b1 || cnt !== 8'd2) begin
            n_err++;
            $display("FAIL back_to_back: y=%h out_valid=%b cnt=%0d, required y=03 out_valid=1 cnt=2",
                     y, out_valid, cnt);
        end
        drive(1'b0, '0, '0, 3'd0, 1'b0, 1'b1);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_drain: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_c [5];
        exp_c = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(i), 8'h0F, 3'd0, 1'b0, 1'b1);
            n_vec++;
            if (cnt2 !== exp_c[i]) begin
                n_err++;
                $display("FAIL sat_cnt%0d: cnt=%0d required %0d", i, cnt2, exp_c[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        drive(1'b1, 8'h01, 8'h00, 3'd6, 1'b1, 1'b1);
        drive(1'b1, 8'h00, 8'h10, 3'd6, 1'b0, 1'b1);
        drive(1'b1, 8'h80, 8'h80, 3'd6, 1'b0, 1'b1);
        n_vec++;
        if (y !== 8'h91 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_pre: y=%h out_valid=%b, required y=91 out_valid=1", y, out_valid);
        end
        rst = 1'b1;
        drive(1'b1, 8'h40, 8'h00, 3'd6, 1'b0, 1'b1);
        rst = 1'b0;
        n_vec++;
        if (y !== 8'h00 || out_valid !== 1'b0 || cnt !== 8'd0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_state: y=%h out_valid=%b cnt=%0d in_ready=%b, required 00/0/0/1",
                     y, out_valid, cnt, in_ready);
        end
        drive(1'b1, 8'h02, 8'h00, 3'd6, 1'b0, 1'b1);
        n_vec++;
        if (y !== 8'h02) begin
            n_err++;
            $display("FAIL midrst_first: y=%h required 02", y);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = 8'($urandom);
            b         = 8'($urandom);
            op        = 3'($urandom_range(0, 7));
            clr       = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            n_vec++;
            if (in_ready !== (!m_ov || out_ready)) begin
                n_err++;
                $display("FAIL rand_in_ready[%0d]: in_ready=%b required %b",
                         i, in_ready, (!m_ov || out_ready));
            end
            drive(in_valid, a, b, op, clr, out_ready);
            n_vec++;
            if (out_valid !== m_ov || cnt !== 8'(m_cnt) || cnt2 !== 2'(m_cnt2)
                || (m_ov && y !== m_y)) begin
                n_err++;
                $display("FAIL rand_out[%0d]: y=%h ov=%b cnt=%0d cnt2=%0d, required y=%h ov=%b cnt=%0d cnt2=%0d",
                         i, y, out_valid, cnt, cnt2, m_y, m_ov, m_cnt, m_cnt2);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; clr = 1'b0; out_ready = 1'b1;
        m_acc = '0; m_first = 1'b1; m_y = '0; m_ov = 1'b0; m_cnt = 0; m_cnt2 = 0;
        #1;
        test_reset();
        test_function_sweep();
        test_accumulate();
        test_backpressure();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
